// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between instruction fetch (IF) and load/store (D).
// D wins by default; IF is forced through once it has lost STARVE_MAX arbitrations in a row.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          wait_cnt_reg, wait_cnt_next;
  logic [3:0]          starve_cnt_reg, starve_cnt_next;
  logic                grant_if;
  logic                mem_en_next, mem_we_next;
  logic [BE_W-1:0]     mem_be_next;
  logic [ADDR_W-1:0]   mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_next;
  logic [DATA_W-1:0]   if_rdata_next, d_rdata_next;
  logic                if_ready_next, d_ready_next;
  logic                busy_next, owner_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= '0;
      starve_cnt_reg <= '0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_be         <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      if_rdata       <= '0;
      d_rdata        <= '0;
      if_ready       <= 1'b0;
      d_ready        <= 1'b0;
      busy           <= 1'b0;
      owner          <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
      mem_en         <= mem_en_next;
      mem_we         <= mem_we_next;
      mem_be         <= mem_be_next;
      mem_addr       <= mem_addr_next;
      mem_wdata      <= mem_wdata_next;
      if_rdata       <= if_rdata_next;
      d_rdata        <= d_rdata_next;
      if_ready       <= if_ready_next;
      d_ready        <= d_ready_next;
      busy           <= busy_next;
      owner          <= owner_next;
    end
  end

  // The memory-side outputs double as the access latches: they are loaded at the
  // grant and held through WAIT, so all outputs come straight from flops.
  always_comb begin
    state_next      = state_reg;
    wait_cnt_next   = wait_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    grant_if        = if_req && (!d_req || (starve_cnt_reg == 4'(STARVE_MAX)));
    mem_en_next     = 1'b0;
    mem_we_next     = mem_we;
    mem_be_next     = mem_be;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;
    if_rdata_next   = if_rdata;
    d_rdata_next    = d_rdata;
    if_ready_next   = 1'b0;
    d_ready_next    = 1'b0;
    owner_next      = owner;

    case (state_reg)
      IDLE: begin
        if (if_req || d_req) begin
          state_next  = ISSUE;
          mem_en_next = 1'b1;
          owner_next  = !grant_if;
          if (grant_if) begin
            mem_addr_next   = if_addr;
            mem_we_next     = 1'b0;
            mem_be_next     = {BE_W{1'b1}};
            mem_wdata_next  = '0;
            starve_cnt_next = '0;
          end else begin
            mem_addr_next  = d_addr;
            mem_we_next    = d_we;
            mem_be_next    = d_be;
            mem_wdata_next = d_wdata;
            if (if_req && (starve_cnt_reg < 4'(STARVE_MAX)))
              starve_cnt_next = starve_cnt_reg + 4'd1;
          end
        end
      end
      ISSUE: begin
        state_next    = WAIT;
        wait_cnt_next = 4'(MEM_LAT);
      end
      WAIT: begin
        wait_cnt_next = wait_cnt_reg - 4'd1;
        if (wait_cnt_reg == 4'd1) begin
          if (!owner)
            if_rdata_next = mem_rdata;
          else if (!mem_we)
            d_rdata_next = mem_rdata;
          state_next    = RESP;
          mem_we_next   = 1'b0;
          mem_be_next   = '0;
          if_ready_next = !owner;
          d_ready_next  = owner;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule
